// File: rtl/action_sender.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : action_sender
// Purpose  : Turns flow-table lookup results into a stream of action words.
//            A hit fetches up to four words from the action RAM at
//            {index, word}. The stream stops after the word whose ctrl
//            bit 7 (last flag) is set, or after the fourth word. A miss
//            emits a single MISS_ACTION word with the last flag set.
//            Hit and miss statistics saturate at all-ones.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk                in   sole clock, rising edge
//   reset_n            in   synchronous active-low reset
//   match_valid        in   lookup result valid
//   match_hit          in   lookup hit (1) / miss (0)
//   match_index        in   flow-entry index of the hit
//   match_rdy          out  result accepted when match_valid && match_rdy
//   act_ram_rd_en      out  action RAM read strobe
//   act_ram_addr       out  action RAM address {index, word}
//   act_ram_data       in   action RAM data, valid 1 cycle after the read
//   act_ram_ctrl       in   action RAM ctrl, valid 1 cycle after the read
//   action_data_bus    out  action word data
//   action_ctrl_bus    out  action word ctrl (bit 7 = last word)
//   action_valid       out  one-cycle strobe per action word
//   action_nearly_full in   consumer can absorb at most one more word
//   hit_count          out  saturating hit counter
//   miss_count         out  saturating miss counter
//============================================================================
module action_sender #(
    parameter int                           ACTION_DATA_WIDTH = 64,
    parameter int                           ACTION_CTRL_WIDTH = 8,
    parameter int                           INDEX_WIDTH       = 8,
    parameter logic [ACTION_DATA_WIDTH-1:0] MISS_ACTION       = 64'h0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         match_valid,
    input  logic                         match_hit,
    input  logic [INDEX_WIDTH-1:0]       match_index,
    output logic                         match_rdy,
    output logic                         act_ram_rd_en,
    output logic [INDEX_WIDTH+1:0]       act_ram_addr,
    input  logic [ACTION_DATA_WIDTH-1:0] act_ram_data,
    input  logic [ACTION_CTRL_WIDTH-1:0] act_ram_ctrl,
    output logic [ACTION_DATA_WIDTH-1:0] action_data_bus,
    output logic [ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
    output logic                         action_valid,
    input  logic                         action_nearly_full,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
);

    // Bit position of the last-word flag inside the ctrl field.
    localparam int C_LAST_BIT = 7;

    localparam logic [ACTION_CTRL_WIDTH-1:0] C_LAST_FLAG =
        ACTION_CTRL_WIDTH'(1) << C_LAST_BIT;

    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    // An entry holds at most four words; the word counter tops out here.
    localparam logic [1:0] C_WORD_MAX = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        MISS  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [INDEX_WIDTH-1:0]         index_q, index_d;
    logic [1:0]                     word_q,  word_d;
    logic [ACTION_DATA_WIDTH-1:0]   data_q,  data_d;
    logic [ACTION_CTRL_WIDTH-1:0]   ctrl_q,  ctrl_d;
    logic                           valid_q, valid_d;
    logic [31:0]                    hit_q,   hit_d;
    logic [31:0]                    miss_q,  miss_d;

    logic                           accept;
    logic                           last_word;

    // The address is always {entry, word}; it only matters while the read
    // strobe is high, so it is left free-running from the registers.
    assign act_ram_addr = {index_q, word_q};

    assign accept    = match_valid && match_rdy;

    // Entry ends on the RAM's own last flag or when the fourth word is read.
    assign last_word = act_ram_ctrl[C_LAST_BIT] || (word_q == C_WORD_MAX);

    //------------------------------------------------------------------------
    // Next-state and output decode
    //------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        word_d        = word_q;
        data_d        = data_q;
        ctrl_d        = ctrl_q;
        valid_d       = 1'b0;
        hit_d         = hit_q;
        miss_d        = miss_q;
        match_rdy     = 1'b0;
        act_ram_rd_en = 1'b0;

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted
                // in the cycle the state is being cleared.
                match_rdy = reset_n;
                if (accept) begin
                    if (match_hit) begin
                        index_d = match_index;
                        word_d  = 2'd0;
                        state_d = FETCH;
                        hit_d   = (hit_q == C_CNT_MAX) ? hit_q : hit_q + 32'd1;
                    end else begin
                        state_d = MISS;
                        miss_d  = (miss_q == C_CNT_MAX) ? miss_q : miss_q + 32'd1;
                    end
                end
            end

            FETCH: begin
                // Only read when the consumer has room, so that the word
                // in flight can always be delivered.
                if (!action_nearly_full) begin
                    act_ram_rd_en = 1'b1;
                    state_d       = LATCH;
                end
            end

            LATCH: begin
                data_d  = act_ram_data;
                ctrl_d  = (word_q == C_WORD_MAX) ? (act_ram_ctrl | C_LAST_FLAG)
                                                 : act_ram_ctrl;
                valid_d = 1'b1;
                if (last_word) begin
                    state_d = IDLE;
                end else begin
                    word_d  = word_q + 2'd1;
                    state_d = FETCH;
                end
            end

            MISS: begin
                if (!action_nearly_full) begin
                    data_d  = MISS_ACTION;
                    ctrl_d  = C_LAST_FLAG;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // State registers. Reset discards any entry in progress; a RAM word
    // requested in the reset cycle is never latched because LATCH is not
    // reached.
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            index_q <= '0;
            word_q  <= 2'd0;
            data_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            hit_q   <= 32'd0;
            miss_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            word_q  <= word_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign action_data_bus = data_q;
    assign action_ctrl_bus = ctrl_q;
    assign action_valid    = valid_q;
    assign hit_count       = hit_q;
    assign miss_count      = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_action_sender.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_action_sender
// Purpose  : Directed self-checking bench for action_sender. A small
//            behavioural RAM answers reads one cycle later; monitors log
//            every read and every emitted action word with its cycle number.
// Revision : 1.0 - initial release
//============================================================================
module tb_action_sender;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int IW = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            match_valid;
    logic            match_hit;
    logic [IW-1:0]   match_index;
    logic            match_rdy;
    logic            act_ram_rd_en;
    logic [IW+1:0]   act_ram_addr;
    logic [DW-1:0]   act_ram_data;
    logic [CW-1:0]   act_ram_ctrl;
    logic [DW-1:0]   action_data_bus;
    logic [CW-1:0]   action_ctrl_bus;
    logic            action_valid;
    logic            action_nearly_full;
    logic [31:0]     hit_count;
    logic [31:0]     miss_count;

    action_sender #(
        .ACTION_DATA_WIDTH (DW),
        .ACTION_CTRL_WIDTH (CW),
        .INDEX_WIDTH       (IW),
        .MISS_ACTION       (64'hDEAD)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .match_valid        (match_valid),
        .match_hit          (match_hit),
        .match_index        (match_index),
        .match_rdy          (match_rdy),
        .act_ram_rd_en      (act_ram_rd_en),
        .act_ram_addr       (act_ram_addr),
        .act_ram_data       (act_ram_data),
        .act_ram_ctrl       (act_ram_ctrl),
        .action_data_bus    (action_data_bus),
        .action_ctrl_bus    (action_ctrl_bus),
        .action_valid       (action_valid),
        .action_nearly_full (action_nearly_full),
        .hit_count          (hit_count),
        .miss_count         (miss_count)
    );

    always #5 clk = ~clk;

    // Behavioural action RAM, one-cycle read latency.
    logic [DW-1:0] mem_d [0:1023];
    logic [CW-1:0] mem_c [0:1023];

    always @(posedge clk) begin
        if (act_ram_rd_en) begin
            act_ram_data <= mem_d[act_ram_addr];
            act_ram_ctrl <= mem_c[act_ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sample on the falling edge, away from the active edge.
    logic [DW-1:0] vq_data [$];
    logic [CW-1:0] vq_ctrl [$];
    int            vq_cyc  [$];
    logic [IW+1:0] rq_addr [$];
    int            rq_cyc  [$];
    int            rd_while_full = 0;

    always @(negedge clk) begin
        if (action_valid === 1'b1) begin
            vq_data.push_back(action_data_bus);
            vq_ctrl.push_back(action_ctrl_bus);
            vq_cyc.push_back(cyc);
        end
        if (act_ram_rd_en === 1'b1) begin
            rq_addr.push_back(act_ram_addr);
            rq_cyc.push_back(cyc);
            if (action_nearly_full) rd_while_full = rd_while_full + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        vq_data.delete(); vq_ctrl.delete(); vq_cyc.delete();
        rq_addr.delete(); rq_cyc.delete();
    endtask

    // Presents one lookup result and holds it until it is accepted.
    task automatic do_match(input logic hit, input logic [IW-1:0] idx);
        int n;
        n = 0;
        match_valid = 1'b1;
        match_hit   = hit;
        match_index = idx;
        while (match_rdy !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_bad++;
            $display("FAIL accept_timeout: match_rdy=%b required 1", match_rdy);
        end
        tick(1);
        match_valid = 1'b0;
        match_hit   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        n_cmp++;
        if (match_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_rdy_low: got %b required 0", match_rdy); end
        n_cmp++;
        if (action_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b required 0", action_valid); end
        n_cmp++;
        if (act_ram_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b required 0", act_ram_rd_en); end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (match_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy_after: got %b required 1", match_rdy); end
        n_cmp++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_bad++; $display("FAIL rst_counts: got hit=%0d miss=%0d required 0/0", hit_count, miss_count);
        end
        n_cmp++;
        if (action_data_bus !== 64'd0 || action_ctrl_bus !== 8'd0) begin
            n_bad++; $display("FAIL rst_bus: got %h/%h required 0/0", action_data_bus, action_ctrl_bus);
        end
        tick(1);
    endtask

    task automatic test_two_word();
        mem_d[10'h14] = 64'hA5A5_0000_1234_0001; mem_c[10'h14] = 8'h00;
        mem_d[10'h15] = 64'h5A5A_FFFF_0000_0002; mem_c[10'h15] = 8'h80;
        clear_logs();
        do_match(1'b1, 8'h05);
        tick(12);
        n_cmp++;
        if (rq_addr.size() != 2) begin n_bad++; $display("FAIL two_nreads: got %0d required 2", rq_addr.size()); end
        else begin
            n_cmp++;
            if (rq_addr[0] !== 10'h14 || rq_addr[1] !== 10'h15) begin
                n_bad++; $display("FAIL two_addr: got %h,%h required 014,015", rq_addr[0], rq_addr[1]);
            end
        end
        n_cmp++;
        if (vq_data.size() != 2) begin n_bad++; $display("FAIL two_nvalid: got %0d required 2", vq_data.size()); end
        else begin
            n_cmp++;
            if (vq_data[0] !== 64'hA5A5_0000_1234_0001 || vq_data[1] !== 64'h5A5A_FFFF_0000_0002) begin
                n_bad++; $display("FAIL two_data: got %h,%h", vq_data[0], vq_data[1]);
            end
            n_cmp++;
            if (vq_ctrl[0] !== 8'h00 || vq_ctrl[1] !== 8'h80) begin
                n_bad++; $display("FAIL two_ctrl: got %h,%h required 00,80", vq_ctrl[0], vq_ctrl[1]);
            end
            n_cmp++;
            if (vq_cyc[1] - vq_cyc[0] != 2) begin
                n_bad++; $display("FAIL two_gap: got %0d required 2", vq_cyc[1] - vq_cyc[0]);
            end
            if (rq_cyc.size() >= 1) begin
                n_cmp++;
                if (vq_cyc[0] - rq_cyc[0] != 2) begin
                    n_bad++; $display("FAIL two_latency: got %0d required 2", vq_cyc[0] - rq_cyc[0]);
                end
            end
        end
        n_cmp++;
        if (hit_count !== 32'd1 || miss_count !== 32'd0) begin
            n_bad++; $display("FAIL two_counts: got hit=%0d miss=%0d required 1/0", hit_count, miss_count);
        end
    endtask

    task automatic test_four_word();
        logic [CW-1:0] exp_c [4];
        exp_c[0] = 8'h00; exp_c[1] = 8'h00; exp_c[2] = 8'h00; exp_c[3] = 8'h80;
        for (int k = 0; k < 4; k++) begin
            mem_d[4 + k] = 64'hC0DE_0000_0000_0000 + 64'(k);
            mem_c[4 + k] = 8'h00;
        end
        clear_logs();
        do_match(1'b1, 8'h01);
        tick(16);
        n_cmp++;
        if (rq_addr.size() != 4) begin n_bad++; $display("FAIL four_nreads: got %0d required 4", rq_addr.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (rq_addr[k] !== 10'(4 + k)) begin
                    n_bad++; $display("FAIL four_addr%0d: got %h required %h", k, rq_addr[k], 10'(4 + k));
                end
            end
        end
        n_cmp++;
        if (vq_data.size() != 4) begin n_bad++; $display("FAIL four_nvalid: got %0d required 4", vq_data.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (vq_data[k] !== 64'hC0DE_0000_0000_0000 + 64'(k) || vq_ctrl[k] !== exp_c[k]) begin
                    n_bad++; $display("FAIL four_word%0d: got %h/%h required ctrl %h", k, vq_data[k], vq_ctrl[k], exp_c[k]);
                end
            end
        end
        n_cmp++;
        if (match_rdy !== 1'b1) begin n_bad++; $display("FAIL four_idle: match_rdy=%b required 1", match_rdy); end
        n_cmp++;
        if (hit_count !== 32'd2) begin n_bad++; $display("FAIL four_hits: got %0d required 2", hit_count); end
    endtask

    task automatic test_miss();
        clear_logs();
        do_match(1'b0, 8'h33);
        tick(6);
        n_cmp++;
        if (rq_addr.size() != 0) begin n_bad++; $display("FAIL miss_reads: got %0d required 0", rq_addr.size()); end
        n_cmp++;
        if (vq_data.size() != 1) begin n_bad++; $display("FAIL miss_nvalid: got %0d required 1", vq_data.size()); end
        else begin
            n_cmp++;
            if (vq_data[0] !== 64'hDEAD || vq_ctrl[0] !== 8'h80) begin
                n_bad++; $display("FAIL miss_word: got %h/%h required dead/80", vq_data[0], vq_ctrl[0]);
            end
        end
        n_cmp++;
        if (miss_count !== 32'd1 || hit_count !== 32'd2) begin
            n_bad++; $display("FAIL miss_counts: got hit=%0d miss=%0d required 2/1", hit_count, miss_count);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            mem_d[8 + k] = 64'h0000_BEEF_0000_0000 + 64'(k);
            mem_c[8 + k] = (k == 2) ? 8'h80 : 8'h00;
        end
        clear_logs();
        do_match(1'b1, 8'h02);
        tick(2);                     // first word now on the bus, second read due
        action_nearly_full = 1'b1;
        tick(10);
        action_nearly_full = 1'b0;
        n_cmp++;
        if (rq_addr.size() != 1 || vq_data.size() != 1) begin
            n_bad++; $display("FAIL stall_hold: got reads=%0d valids=%0d required 1/1", rq_addr.size(), vq_data.size());
        end
        tick(12);
        n_cmp++;
        if (rq_addr.size() != 3) begin n_bad++; $display("FAIL stall_nreads: got %0d required 3", rq_addr.size()); end
        else begin
            n_cmp++;
            if (rq_addr[0] !== 10'h008 || rq_addr[1] !== 10'h009 || rq_addr[2] !== 10'h00A) begin
                n_bad++; $display("FAIL stall_addr: got %h,%h,%h required 008,009,00a", rq_addr[0], rq_addr[1], rq_addr[2]);
            end
        end
        n_cmp++;
        if (vq_data.size() != 3) begin n_bad++; $display("FAIL stall_nvalid: got %0d required 3", vq_data.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vq_data[k] !== 64'h0000_BEEF_0000_0000 + 64'(k)) begin
                    n_bad++; $display("FAIL stall_word%0d: got %h", k, vq_data[k]);
                end
            end
            n_cmp++;
            if (vq_ctrl[2] !== 8'h80) begin n_bad++; $display("FAIL stall_last: got %h required 80", vq_ctrl[2]); end
        end
        n_cmp++;
        if (rd_while_full != 0) begin n_bad++; $display("FAIL rd_while_full: got %0d required 0", rd_while_full); end
        n_cmp++;
        if (hit_count !== 32'd3) begin n_bad++; $display("FAIL stall_hits: got %0d required 3", hit_count); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            mem_d[12 + k] = 64'h0000_0000_0000_7000 + 64'(k);
            mem_c[12 + k] = (k == 2) ? 8'h80 : 8'h00;
        end
        clear_logs();
        do_match(1'b1, 8'h03);
        tick(2);                     // word 1 on the bus, word 2 read in progress
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(10);
        n_cmp++;
        if (vq_data.size() != 1) begin n_bad++; $display("FAIL rmid_nvalid: got %0d required 1", vq_data.size()); end
        else begin
            n_cmp++;
            if (vq_data[0] !== 64'h7000) begin n_bad++; $display("FAIL rmid_word1: got %h required 7000", vq_data[0]); end
        end
        n_cmp++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_bad++; $display("FAIL rmid_counts: got hit=%0d miss=%0d required 0/0", hit_count, miss_count);
        end
        clear_logs();
        do_match(1'b0, 8'h40);
        tick(6);
        n_cmp++;
        if (vq_data.size() != 1) begin n_bad++; $display("FAIL rmid_next_nvalid: got %0d required 1", vq_data.size()); end
        else begin
            n_cmp++;
            if (vq_data[0] !== 64'hDEAD) begin n_bad++; $display("FAIL rmid_next_word: got %h required dead", vq_data[0]); end
        end
        n_cmp++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            n_bad++; $display("FAIL rmid_next_counts: got hit=%0d miss=%0d required 0/1", hit_count, miss_count);
        end
    endtask

    task automatic test_saturation();
        force dut.hit_q = 32'hFFFF_FFFE;
        tick(1);
        release dut.hit_q;
        clear_logs();
        do_match(1'b1, 8'h05);
        tick(10);
        n_cmp++;
        if (hit_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_first: got %h required ffffffff", hit_count); end
        do_match(1'b1, 8'h05);
        tick(10);
        n_cmp++;
        if (hit_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_hold: got %h required ffffffff", hit_count); end
        n_cmp++;
        if (vq_data.size() != 4) begin n_bad++; $display("FAIL sat_words: got %0d required 4", vq_data.size()); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_d[i] = 64'hFFFF_0000_0000_0000 + 64'(i);
            mem_c[i] = 8'h00;
        end
        reset_n            = 1'b0;
        match_valid        = 1'b0;
        match_hit          = 1'b0;
        match_index        = '0;
        action_nearly_full = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_two_word();
        test_four_word();
        test_miss();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/action_sender.md
ACTION_SENDER -- requirements
Module: action_sender

Interface
REQ-001 SHALL have parameter ACTION_DATA_WIDTH, default 64, action word data width.
REQ-002 SHALL have parameter ACTION_CTRL_WIDTH, default 8, action word ctrl width; bit 7 = last-word flag.
REQ-003 SHALL have parameter INDEX_WIDTH, default 8, flow-entry index width.
REQ-004 SHALL have parameter MISS_ACTION, default 64'h0, data word emitted on a table miss.
REQ-005 SHALL have ports: clk  in  1  sole clock; one clock, reset is synchronous and active-low.
REQ-006 SHALL have ports: reset_n  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: match_valid  in  1; match_hit  in  1; match_index  in  INDEX_WIDTH: lookup result from matcher.
REQ-008 SHALL have port match_rdy  out  1  result accepted when match_valid && match_rdy at a rising edge.
REQ-009 SHALL have ports: act_ram_rd_en  out  1; act_ram_addr  out  INDEX_WIDTH+2  ({index, word}).
REQ-010 SHALL have ports: act_ram_data  in  ACTION_DATA_WIDTH; act_ram_ctrl  in  ACTION_CTRL_WIDTH; valid exactly 1 cycle after act_ram_rd_en.
REQ-011 SHALL have ports: action_data_bus  out  ACTION_DATA_WIDTH; action_ctrl_bus  out  ACTION_CTRL_WIDTH; action_valid  out  1: action stream to the action processor.
REQ-012 SHALL have port action_nearly_full  in  1  consumer FIFO can absorb at most one more word.
REQ-013 SHALL have ports hit_count, miss_count  out  32 each  statistics.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, LATCH, MISS.
REQ-015 SHALL assert match_rdy only in IDLE; match_valid held while busy is not accepted.
REQ-016 SHALL on accept with match_hit=1 register index, clear 2-bit word counter w, go to FETCH, increment hit_count.
REQ-017 SHALL on accept with match_hit=0 go to MISS, increment miss_count.
REQ-018 SHALL in FETCH, if action_nearly_full=0, assert act_ram_rd_en for one cycle with addr {index,w} and go to LATCH; else stay in FETCH with act_ram_rd_en=0.
REQ-019 SHALL in LATCH register act_ram_data/act_ram_ctrl into the output bus registers and set action_valid for the next cycle only.
REQ-020 SHALL force output ctrl bit 7 to 1 when w=3 (4-word maximum per entry).
REQ-021 SHALL leave LATCH to IDLE if act_ram_ctrl[7]=1 or w=3; otherwise increment w and go to FETCH.
REQ-022 SHALL in MISS, if action_nearly_full=0, load MISS_ACTION and ctrl 8'h80, set action_valid for one cycle, go to IDLE; else remain in MISS.
REQ-023 SHALL assert action_valid for exactly one cycle per word; each word of an entry appears 2 cycles after its FETCH read cycle.
REQ-024 SHALL drive bus registers unchanged while action_valid=0 (no requirement on value).
REQ-025 SHALL saturate hit_count and miss_count at 32'hFFFFFFFF.
REQ-026 SHALL never issue act_ram_rd_en outside FETCH, nor in a cycle with action_nearly_full=1.

Reset
REQ-027 SHALL, when reset_n=0 at a rising edge, set state IDLE, w=0, action_valid=0, act_ram_rd_en=0, bus registers 0, hit_count=0, miss_count=0.
REQ-028 SHALL abandon any entry in progress on reset; no further words of it are emitted, and a word whose read was issued in the reset cycle is discarded.
REQ-029 SHALL drive match_rdy=0 during reset and 1 in the first cycle after reset_n returns high.

Verification
REQ-030 Hit, idx 0x05, RAM words at 0x14/0x15 with ctrl 0x00/0x80 -> reads at addr 0x14, 0x15; two valid pulses, 2 cycles apart; second ctrl 0x80; hit_count=1.
REQ-031 Hit, idx 0x01, four words all ctrl 0x00 -> exactly 4 valid pulses, 4th ctrl bit7 forced 1, return to IDLE.
REQ-032 Miss with MISS_ACTION=64'hDEAD -> one valid pulse, data 0xDEAD, ctrl 0x80; miss_count=1; no RAM read.
REQ-033 action_nearly_full high 10 cycles during 3-word entry -> no reads, no valid during stall; all 3 words delivered in order after release.
REQ-034 reset_n low for one cycle between word 1 and word 2 of a 3-word entry -> no further valid pulses, counters 0, next match accepted normally.
REQ-035 hit_count preset near 32'hFFFFFFFF via 2 extra hits -> stays 32'hFFFFFFFF.
